// File: rtl/byte_unstriping.sv
// Merges two paired byte lanes into one clk_2f byte stream (lane 0 first, then lane 1),
// counting emitted bytes and completed bursts and flagging lane skew.
module byte_unstriping #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk_2f,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  data_stripe_0,
  input  logic                   valid_stripe_0,
  input  logic [DATA_WIDTH-1:0]  data_stripe_1,
  input  logic                   valid_stripe_1,
  input  logic                   err_clr,
  output logic [DATA_WIDTH-1:0]  data_unstripe,
  output logic                   valid_unstripe,
  output logic [COUNT_WIDTH-1:0] byte_count,
  output logic [7:0]             burst_count,
  output logic                   err_skew
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    P1   = 2'd1,
    P0   = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] data_nxt;
  logic                  valid_nxt;
  logic [DATA_WIDTH-1:0] hold1, hold1_nxt;
  logic                  hold1_v, hold1_v_nxt;
  logic                  odd_pending, odd_pending_nxt;
  logic                  burst_end;
  logic                  skew_set;

  // odd_pending lives for the one sampling slot right after an odd-length burst end;
  // a lane 0 byte arriving there means lane 1 lost a byte mid-burst.
  always_comb begin
    state_nxt       = state;
    data_nxt        = data_unstripe;
    valid_nxt       = 1'b0;
    hold1_nxt       = hold1;
    hold1_v_nxt     = hold1_v;
    odd_pending_nxt = 1'b0;
    burst_end       = 1'b0;
    skew_set        = 1'b0;

    case (state)
      IDLE, P0: begin
        if (valid_stripe_0) begin
          data_nxt    = data_stripe_0;
          valid_nxt   = 1'b1;
          hold1_nxt   = data_stripe_1;
          hold1_v_nxt = valid_stripe_1;
          state_nxt   = P1;
          if (odd_pending) skew_set = 1'b1;
        end else begin
          state_nxt = IDLE;
          if (state == P0) burst_end = 1'b1;
          if (valid_stripe_1) skew_set = 1'b1;
        end
      end
      P1: begin
        data_nxt  = hold1;
        valid_nxt = hold1_v;
        if (hold1_v) begin
          state_nxt = P0;
        end else begin
          burst_end       = 1'b1;
          odd_pending_nxt = 1'b1;
          state_nxt       = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      data_unstripe  <= '0;
      valid_unstripe <= 1'b0;
      hold1          <= '0;
      hold1_v        <= 1'b0;
      odd_pending    <= 1'b0;
      byte_count     <= '0;
      burst_count    <= '0;
      err_skew       <= 1'b0;
    end else begin
      state          <= state_nxt;
      data_unstripe  <= data_nxt;
      valid_unstripe <= valid_nxt;
      hold1          <= hold1_nxt;
      hold1_v        <= hold1_v_nxt;
      odd_pending    <= odd_pending_nxt;
      if (valid_nxt) byte_count <= byte_count + COUNT_WIDTH'(1);
      if (burst_end && (burst_count != 8'hFF)) burst_count <= burst_count + 8'd1;
      // A new skew event beats a simultaneous clear
      if (skew_set) err_skew <= 1'b1;
      else if (err_clr) err_skew <= 1'b0;
    end
  end

endmodule

// File: tb/tb_byte_unstriping.sv
// Directed self-checking bench for byte_unstriping, built with a 4-bit byte counter
// so the wrap boundary is reachable.
module tb_byte_unstriping;

  logic       clk_2f = 1'b0;
  logic       reset;
  logic [7:0] data_stripe_0, data_stripe_1;
  logic       valid_stripe_0, valid_stripe_1;
  logic       err_clr;
  logic [7:0] data_unstripe;
  logic       valid_unstripe;
  logic [3:0] byte_count;
  logic [7:0] burst_count;
  logic       err_skew;

  int compared   = 0;
  int mismatched = 0;

  byte_unstriping #(.DATA_WIDTH(8), .COUNT_WIDTH(4)) dut (
    .clk_2f         (clk_2f),
    .reset          (reset),
    .data_stripe_0  (data_stripe_0),
    .valid_stripe_0 (valid_stripe_0),
    .data_stripe_1  (data_stripe_1),
    .valid_stripe_1 (valid_stripe_1),
    .err_clr        (err_clr),
    .data_unstripe  (data_unstripe),
    .valid_unstripe (valid_unstripe),
    .byte_count     (byte_count),
    .burst_count    (burst_count),
    .err_skew       (err_skew)
  );

  always #5 clk_2f = ~clk_2f;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d0, input logic v0, input logic [7:0] d1,
                               input logic v1, input logic clr);
    data_stripe_0  = d0;
    valid_stripe_0 = v0;
    data_stripe_1  = d1;
    valid_stripe_1 = v1;
    err_clr        = clr;
  endtask

  task automatic tick();
    @(posedge clk_2f);
    #1;
  endtask

  task automatic checkByte(input string tag, input logic [7:0] expected);
    checkOutput({tag, "_valid"}, 32'(valid_unstripe), 32'd1);
    checkOutput({tag, "_data"}, 32'(data_unstripe), 32'(expected));
  endtask

  task automatic pulseReset();
    #2 reset = 1'b1;
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    checkOutput("rst_data", 32'(data_unstripe), 32'd0);
    checkOutput("rst_valid", 32'(valid_unstripe), 32'd0);
    checkOutput("rst_bytes", 32'(byte_count), 32'd0);
    checkOutput("rst_bursts", 32'(burst_count), 32'd0);
    checkOutput("rst_err", 32'(err_skew), 32'd0);

    // Continuous three-pair burst
    applyStimulus(8'h11, 1'b1, 8'h22, 1'b1, 1'b0);
    #2 checkOutput("cont_pre_valid", 32'(valid_unstripe), 32'd0);
    tick(); checkByte("cont_11", 8'h11);
    tick(); checkByte("cont_22", 8'h22);
    applyStimulus(8'h33, 1'b1, 8'h44, 1'b1, 1'b0);
    tick(); checkByte("cont_33", 8'h33);
    tick(); checkByte("cont_44", 8'h44);
    applyStimulus(8'h55, 1'b1, 8'h66, 1'b1, 1'b0);
    tick(); checkByte("cont_55", 8'h55);
    tick(); checkByte("cont_66", 8'h66);
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("cont_end_valid", 32'(valid_unstripe), 32'd0);
    checkOutput("cont_bytes", 32'(byte_count), 32'd6);
    checkOutput("cont_bursts", 32'(burst_count), 32'd1);

    // Odd-length burst
    applyStimulus(8'hA0, 1'b1, 8'hA1, 1'b1, 1'b0);
    tick(); checkByte("odd_a0", 8'hA0);
    tick(); checkByte("odd_a1", 8'hA1);
    applyStimulus(8'hB0, 1'b1, 8'h00, 1'b0, 1'b0);
    tick(); checkByte("odd_b0", 8'hB0);
    tick(); checkOutput("odd_end_valid", 32'(valid_unstripe), 32'd0);
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("odd_bytes", 32'(byte_count), 32'd9);
    checkOutput("odd_bursts", 32'(burst_count), 32'd2);
    checkOutput("odd_err", 32'(err_skew), 32'd0);

    // Lane 1 without lane 0: dropped and flagged; clear; clear loses to set
    applyStimulus(8'h00, 1'b0, 8'h5A, 1'b1, 1'b0);
    tick();
    checkOutput("skew_valid", 32'(valid_unstripe), 32'd0);
    checkOutput("skew_err", 32'(err_skew), 32'd1);
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    tick(); checkOutput("skew_clr", 32'(err_skew), 32'd0);
    applyStimulus(8'h00, 1'b0, 8'h5A, 1'b1, 1'b1);
    tick(); checkOutput("skew_set_wins", 32'(err_skew), 32'd1);
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("skew_sticky", 32'(err_skew), 32'd1);
    checkOutput("skew_bytes", 32'(byte_count), 32'd9);

    // Lane 0 right after an odd end: flagged, byte still emitted
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    tick(); checkOutput("late_clr", 32'(err_skew), 32'd0);
    applyStimulus(8'hC0, 1'b1, 8'h00, 1'b0, 1'b0);
    tick(); checkByte("late_c0", 8'hC0);
    tick(); checkOutput("late_gap_valid", 32'(valid_unstripe), 32'd0);
    checkOutput("late_gap_err", 32'(err_skew), 32'd0);
    applyStimulus(8'hD0, 1'b1, 8'hD1, 1'b1, 1'b0);
    tick(); checkByte("late_d0", 8'hD0);
    checkOutput("late_err", 32'(err_skew), 32'd1);
    tick(); checkByte("late_d1", 8'hD1);
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("late_bytes", 32'(byte_count), 32'd12);
    checkOutput("late_bursts", 32'(burst_count), 32'd4);

    // Asynchronous reset while 0x77 is held in P1
    applyStimulus(8'h76, 1'b1, 8'h77, 1'b1, 1'b0);
    tick(); checkByte("mid_76", 8'h76);
    #2 reset = 1'b1;
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    checkOutput("async_data", 32'(data_unstripe), 32'd0);
    checkOutput("async_valid", 32'(valid_unstripe), 32'd0);
    checkOutput("async_bytes", 32'(byte_count), 32'd0);
    checkOutput("async_bursts", 32'(burst_count), 32'd0);
    checkOutput("async_err", 32'(err_skew), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    checkOutput("post_rst_valid", 32'(valid_unstripe), 32'd0);
    checkOutput("post_rst_data", 32'(data_unstripe), 32'd0);
    applyStimulus(8'h01, 1'b1, 8'h02, 1'b1, 1'b0);
    tick(); checkByte("post_01", 8'h01);
    tick(); checkByte("post_02", 8'h02);
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("post_bytes", 32'(byte_count), 32'd2);
    checkOutput("post_bursts", 32'(burst_count), 32'd1);

    // 17 bytes into a 4-bit counter wraps to 1
    pulseReset();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(8'(2 * i), 1'b1, 8'(2 * i + 1), 1'b1, 1'b0);
      repeat (2) tick();
    end
    applyStimulus(8'hEE, 1'b1, 8'h00, 1'b0, 1'b0);
    tick(); checkByte("wrap_ee", 8'hEE);
    tick();
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("wrap_bytes", 32'(byte_count), 32'd1);
    checkOutput("wrap_bursts", 32'(burst_count), 32'd1);

    // Burst counter saturation
    for (int i = 0; i < 253; i++) begin
      applyStimulus(8'h3C, 1'b1, 8'hC3, 1'b1, 1'b0);
      repeat (2) tick();
      applyStimulus(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
      tick();
    end
    checkOutput("sat_254", 32'(burst_count), 32'd254);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(8'h3C, 1'b1, 8'hC3, 1'b1, 1'b0);
      repeat (2) tick();
      applyStimulus(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
      tick();
    end
    checkOutput("sat_255", 32'(burst_count), 32'd255);
    checkOutput("sat_bytes", 32'(byte_count), 32'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
